// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- buffered 8N1 serial transmitter
//
// Bytes offered on data/valid are queued in a small FIFO and shifted out
// LSB first on tx as start bit, 8 data bits and one stop bit.  Back-to-back
// bytes are sent with no idle gap between stop and the next start bit.
//
// Parameters
//   CLKRATE   input clock frequency in Hz
//   BAUDRATE  serial bit rate in bit/s; one bit lasts CLKRATE/BAUDRATE clocks
//   DEPTH     FIFO entries, power of two, at least 2
//
// Ports
//   clk    in   sole clock, rising edge
//   rst_n  in   synchronous active-low reset
//   data   in   byte to transmit
//   valid  in   data is offered this cycle
//   ready  out  FIFO can accept a byte this cycle (registered !full)
//   tx     out  serial line, idle high, driven straight from a flop
//   busy   out  FIFO non-empty or a frame in progress
//   link   out  activity indicator, stretched 2^16 clocks after the last frame
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKRATE  = 12_000_000,
    parameter int BAUDRATE = 115_200,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       link
);

    localparam int DIVISOR = CLKRATE / BAUDRATE;
    localparam int BAUD_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LINK_W  = 16;

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(DIVISOR - 1);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;

    logic push;
    logic pop;

    assign push = valid && ready;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;   // idle, or push and pop cancel out
        endcase
    end

    // NOTE: the storage array carries no reset; only pointers and count do.
    // Stale entries are never read because count gates every pop, and an
    // unreset array maps onto plain RAM/flop banks without a reset tree.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    // ------------------------------------------------------------------
    // Transmit state machine: next-state and datapath
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_next;
    logic [7:0]        shift;
    logic [7:0]        shift_next;
    logic [BAUD_W-1:0] baud;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_next;
    logic              tx_next;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        shift_next = shift;
        baud_next  = baud;
        bit_next   = bit_idx;
        tx_next    = tx;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    tx_next    = 1'b0;
                    baud_next  = '0;
                    state_next = START;
                end
            end

            START: begin
                if (baud == BAUD_LAST) begin
                    tx_next    = shift[0];
                    bit_next   = '0;
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end

            DATA: begin
                if (baud == BAUD_LAST) begin
                    shift_next = {1'b0, shift[7:1]};
                    baud_next  = '0;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        // shift[1] is the bit that lands in shift[0] this edge
                        tx_next  = shift[1];
                        bit_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end

            STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_next = '0;
                    if (count != '0) begin
                        // chain straight into the next start bit, no idle gap
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end

            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [LINK_W-1:0] link_cnt;

    // NOTE: all state updates use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            baud     <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready    <= 1'b0;
            link_cnt <= '0;
            link     <= 1'b0;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            baud    <= baud_next;
            bit_idx <= bit_next;
            tx      <= tx_next;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;   // wraps modulo DEPTH
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            ready <= (count_next != FULL_COUNT);

            // The stretch counter is held at its maximum for every clock a
            // frame is active and counts down once idle, so link stays high
            // for exactly 2^16 clocks after the return to IDLE; a new frame
            // reloads it.
            if (state != IDLE) begin
                link_cnt <= '1;
            end else if (link_cnt != '0) begin
                link_cnt <= link_cnt - 1'b1;
            end
            link <= (state_next != IDLE) || (link_cnt != '0);
        end
    end

    assign busy = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx at default parameters
// (104 clocks per bit, 4-entry FIFO).  A background monitor slices tx into
// 10-bit frames and records the start cycle of each and whether the line
// moved inside any bit period.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int DIV   = 104;        // 12 MHz / 115200 baud, truncated
    localparam int FRAME = 10 * DIV;   // 1040 clocks per 8N1 frame

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       link;

    uart_tx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .busy  (busy),
        .link  (link)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far; read on falling edges
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Line monitor
    // ------------------------------------------------------------------
    typedef struct {
        logic [9:0] bits;    // bits[0] = start, bits[8:1] = data, bits[9] = stop
        int         start;   // cycle of the first low sample
        bit         bad;     // line changed inside a bit period
    } frame_t;

    frame_t rx_q[$];
    int     aborted = 0;

    initial begin : monitor
        frame_t f;
        bit     hit_reset;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                f.start   = cyc;
                f.bad     = 1'b0;
                f.bits    = '0;
                hit_reset = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < DIV; j++) begin
                        if (rst_n !== 1'b1) hit_reset = 1'b1;
                        if (j == 0) f.bits[k] = tx;
                        else if (tx !== f.bits[k]) f.bad = 1'b1;
                        if (!(k == 9 && j == DIV - 1)) @(negedge clk);
                    end
                end
                if (hit_reset) aborted++;
                else rx_q.push_back(f);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called on a falling edge, return on a falling edge)
    // ------------------------------------------------------------------
    task automatic push(input logic [7:0] d, output int acc_cyc, output bit accepted);
        accepted = (ready === 1'b1);
        data     = d;
        valid    = 1'b1;
        @(negedge clk);
        acc_cyc  = cyc;     // the edge just taken
        valid    = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_count", rx_q.size(), n);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        logic [9:0] exp_bits;   // {stop, d7..d0, start}
    } vec_t;

    vec_t       vecs [4];
    int         accs [8];
    bit         oks  [8];
    logic [7:0] b2b_exp  [3] = '{8'hA5, 8'h3C, 8'hFF};
    logic [7:0] fill_dat [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bit         fill_ok  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] full_exp [7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77, 8'h88};

    initial begin : main
        int acc;
        int s0;
        int t_end;
        int tx_low;
        bit ok;

        vecs[0] = '{data: 8'h55, exp_bits: 10'b1010101010};
        vecs[1] = '{data: 8'h00, exp_bits: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, exp_bits: 10'b1111111110};
        vecs[3] = '{data: 8'h81, exp_bits: 10'b1100000010};

        // -------- reset state --------
        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx",    tx,    1);
        check("reset_ready", ready, 0);
        check("reset_busy",  busy,  0);
        check("reset_link",  link,  0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", ready, 1);
        check("idle_tx",           tx,    1);

        // -------- single bytes from idle --------
        for (int i = 0; i < 4; i++) begin
            rx_q.delete();
            push(vecs[i].data, acc, ok);
            check($sformatf("vec%0d_accept", i), ok, 1);
            check($sformatf("vec%0d_tx_at_E", i), tx, 1);
            @(negedge clk);
            check($sformatf("vec%0d_tx_at_E1", i), tx, 0);
            wait_frames(1, FRAME + 20);
            if (rx_q.size() > 0) begin
                check($sformatf("vec%0d_bits", i),    rx_q[0].bits,  vecs[i].exp_bits);
                check($sformatf("vec%0d_timing", i),  rx_q[0].bad,   0);
                check($sformatf("vec%0d_latency", i), rx_q[0].start, acc + 1);
            end
            wait_until(acc + 1 + FRAME);
            check($sformatf("vec%0d_busy_done", i), busy, 0);
        end

        // -------- back-to-back bytes --------
        rx_q.delete();
        for (int i = 0; i < 3; i++) push(b2b_exp[i], accs[i], oks[i]);
        for (int i = 0; i < 3; i++) check($sformatf("b2b_accept%0d", i), oks[i], 1);
        s0 = accs[0] + 1;
        wait_frames(3, 3 * FRAME + 50);
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            check($sformatf("b2b_data%0d", i),  rx_q[i].bits[8:1], b2b_exp[i]);
            check($sformatf("b2b_frame%0d", i), {rx_q[i].bits[9], rx_q[i].bits[0]}, 2'b10);
            check($sformatf("b2b_timing%0d", i), rx_q[i].bad, 0);
            check($sformatf("b2b_start%0d", i), rx_q[i].start, s0 + i * FRAME);
        end
        wait_until(s0 + 3 * FRAME);
        check("b2b_busy_done", busy, 0);

        // -------- fill the FIFO, then push exactly on a STOP pop edge --------
        rx_q.delete();
        for (int i = 0; i < 6; i++) push(fill_dat[i], accs[i], oks[i]);
        for (int i = 0; i < 6; i++) check($sformatf("fill_accept%0d", i), oks[i], fill_ok[i]);
        check("full_ready_low", ready, 0);
        s0 = accs[0] + 1;
        wait_until(s0 + FRAME);
        check("ready_after_pop", ready, 1);
        // FIFO now holds 3; offer a byte so it is taken on the next STOP pop
        wait_until(s0 + 2 * FRAME - 1);
        check("ready_before_simul", ready, 1);
        push(8'h77, acc, ok);
        check("simul_accept", ok, 1);
        check("simul_ready_count3", ready, 1);
        push(8'h88, acc, ok);
        check("fourth_accept", ok, 1);
        check("fourth_ready_low", ready, 0);

        // -------- end of traffic: busy and link indicators --------
        t_end = s0 + 7 * FRAME;
        wait_until(t_end - 1);
        check("last_stop_busy", busy, 1);
        check("last_stop_link", link, 1);
        @(negedge clk);
        check("idle_busy",   busy, 0);
        check("idle_link",   link, 1);
        check("idle_tx_end", tx,   1);
        check("full_frames", rx_q.size(), 7);
        for (int i = 0; i < 7 && i < rx_q.size(); i++) begin
            check($sformatf("full_data%0d", i),   rx_q[i].bits[8:1], full_exp[i]);
            check($sformatf("full_timing%0d", i), rx_q[i].bad, 0);
            check($sformatf("full_start%0d", i),  rx_q[i].start, s0 + i * FRAME);
        end
        wait_until(t_end + 65535);
        check("link_stretch_last", link, 1);
        @(negedge clk);
        check("link_stretch_off", link, 0);
        check("no_extra_frames", rx_q.size(), 7);

        // -------- reset in the middle of a frame --------
        rx_q.delete();
        aborted = 0;
        push(8'h0F, accs[0], oks[0]);
        push(8'hAA, accs[1], oks[1]);
        push(8'hBB, accs[2], oks[2]);
        s0 = accs[0] + 1;
        wait_until(s0 + 5 * DIV + 50);         // middle of data bit 4
        check("rst_bit4_level", tx, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_tx",    tx,    1);
        check("rst_busy",  busy,  0);
        check("rst_ready", ready, 0);
        check("rst_link",  link,  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", ready, 1);
        check("rst_release_busy",  busy,  0);
        tx_low = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
        end
        check("rst_tx_stays_high", tx_low, 0);
        check("rst_no_frames",     rx_q.size(), 0);
        check("rst_aborted_once",  aborted, 1);
        check("rst_final_busy",    busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKRATE, default 12_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115_200, serial bit rate in bit/s.
REQ-003 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, minimum 2.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port data  input  8  byte to transmit.
REQ-007 SHALL have port valid  input  1  data is offered this cycle.
REQ-008 SHALL have port ready  output  1  block accepts data this cycle.
REQ-009 SHALL have port tx  output  1  serial line to host, idle high.
REQ-010 SHALL have port busy  output  1  FIFO non-empty or frame in progress.
REQ-011 SHALL have port link  output  1  TX activity indicator for an LED.

Function
REQ-012 SHALL use DIVISOR = CLKRATE/BAUDRATE, integer truncation (defaults: 104); every bit period SHALL last exactly DIVISOR clocks.
REQ-013 SHALL send 8N1 frames: start bit 0, data[0] first through data[7], one stop bit 1; frame = 10*DIVISOR clocks.
REQ-014 SHALL accept a byte on any rising edge where valid=1 and ready=1, writing it to the FIFO tail.
REQ-015 SHALL drive ready = !full, registered; when full, ready=0 even if a pop occurs on the same edge.
REQ-016 SHALL ignore data and valid when ready=0; no FIFO change, no error flag.
REQ-017 SHALL handle a simultaneous push and pop correctly: count unchanged, both entries preserved in order.
REQ-018 SHALL implement FIFO pointers of width log2(DEPTH) that wrap modulo DEPTH, plus a count of width log2(DEPTH)+1.
REQ-019 SHALL implement state machine IDLE, START, DATA, STOP.
REQ-020 IDLE: tx=1; on an edge with FIFO non-empty, pop head into shift register, tx<=0, baud counter<=0, go to START.
REQ-021 START: when baud counter reaches DIVISOR-1, tx<=shift[0], bit index<=0, go to DATA; otherwise increment counter.
REQ-022 DATA: at DIVISOR-1, shift right; after bit index 7, tx<=1 and go to STOP; otherwise tx<=next bit and increment index.
REQ-023 STOP: at DIVISOR-1, if FIFO non-empty, pop, tx<=0 and go to START (no idle gap); else go to IDLE.
REQ-024 SHALL provide the latency: byte accepted at edge E into an empty FIFO in IDLE -> tx low from edge E+1.
REQ-025 SHALL drive tx from a flip-flop only (glitch-free).
REQ-026 SHALL drive busy = (state != IDLE) | (count != 0).
REQ-027 SHALL drive link high while state != IDLE and for 2^16 clocks after returning to IDLE (retriggerable stretch counter).
REQ-028 SHALL leave a frame in progress unaffected by pushes; bytes SHALL be transmitted strictly in acceptance order.

Reset
REQ-029 SHALL, on any edge with rst_n=0, set state=IDLE, tx=1, ready=0, busy=0, link=0, FIFO count/pointers=0, counters=0.
REQ-030 SHALL force ready=1 on the first edge after rst_n returns high.
REQ-031 SHALL abort a frame when reset is asserted mid-frame: tx=1 after that edge; queued bytes are discarded and never sent.

Verification
REQ-032 Single byte: push 0x55 while idle -> tx low after E+1; bits 1,0,1,0,1,0,1,0 then stop, each bit 104 clocks; frame 1040 clocks.
REQ-033 Back-to-back: push 0xA5, 0x3C, 0xFF on consecutive cycles -> three contiguous frames, 3120 clocks total, no idle gap, order preserved.
REQ-034 Full: push 6 bytes with valid held high during the first frame -> ready=0 after the 4 entries fill (1 popped, 4 queued); all accepted bytes sent in order; rejected bytes never sent.
REQ-035 Simultaneous push/pop: FIFO holding 3 bytes, push at the STOP pop edge -> count stays 3, no loss.
REQ-036 Reset mid-frame: rst_n=0 during bit 4 of 0x0F with 2 queued -> tx=1 next edge; busy=0; no further frames after release.
REQ-037 Indicators: after the last stop bit, busy=0 at the IDLE edge; link stays 1 for 65536 clocks, then 0.
